// File: rtl/dnn_input_frame_loader.sv
// Frame loader: collects a serial stream of unsigned pixels into one frame and
// presents it as a zero-extended signed vector until the consumer takes it.
module dnn_input_frame_loader #(
    parameter int unsigned COLS    = 784,
    parameter int unsigned PIXEL_W = 8,
    parameter int unsigned OUT_W   = 9,
    parameter int unsigned CNT_W   = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PIXEL_W-1:0]      s_pixel,
    input  logic                    s_valid,
    input  logic                    s_last,
    output logic                    s_ready,
    output logic signed [OUT_W-1:0] input_vector [0:COLS-1],
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    frame_err,
    output logic [15:0]             frame_count
);

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(COLS - 1);

    typedef enum logic {StFill, StHold} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        idx_q, idx_d;
    logic [15:0]             count_q, count_d;
    logic                    s_ready_q, s_ready_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic signed [OUT_W-1:0] vec_q [0:COLS-1];
    logic                    accept;
    logic                    at_last;

    // s_ready_q is low in HOLD and on the first cycle out of reset, so it alone gates acceptance.
    assign accept  = s_valid && s_ready_q;
    assign at_last = (idx_q == LastIdx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StFill;
            idx_q         <= '0;
            count_q       <= '0;
            s_ready_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            count_q       <= count_d;
            s_ready_q     <= s_ready_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        unique case (state_q)
            StFill: begin
                if (accept) begin
                    if (at_last) begin
                        state_d = StHold;
                        idx_d   = '0;
                    end else if (s_last) begin
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StHold: begin
                if (frame_ready) begin
                    state_d = StFill;
                    idx_d   = '0;
                    count_d = count_q + 16'd1;
                end
            end
            default: state_d = StFill;
        endcase
    end

    // Framing error: s_last disagrees with the final-index position of the beat.
    always_comb begin
        s_ready_d     = (state_d == StFill);
        frame_valid_d = (state_d == StHold);
        frame_err_d   = accept && (s_last != at_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(COLS); i++) begin
                vec_q[i] <= '0;
            end
        end else if (accept) begin
            vec_q[idx_q] <= $signed({{(OUT_W - PIXEL_W){1'b0}}, s_pixel});
        end
    end

    assign s_ready      = s_ready_q;
    assign frame_valid  = frame_valid_q;
    assign frame_err    = frame_err_q;
    assign frame_count  = count_q;
    assign input_vector = vec_q;

endmodule

// File: tb/tb_dnn_input_frame_loader.sv
// Directed bench for dnn_input_frame_loader: table-driven element checks plus
// hand-written sequences for hold, framing errors, reset and throughput.
module tb_dnn_input_frame_loader;

    localparam int COLS = 784;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        s_pixel;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic signed [8:0] iv [0:COLS-1];
    logic              frame_valid;
    logic              frame_ready;
    logic              frame_err;
    logic [15:0]       frame_count;

    always #5 clk = ~clk;

    dnn_input_frame_loader #(
        .COLS    (784),
        .PIXEL_W (8),
        .OUT_W   (9),
        .CNT_W   (10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_pixel      (s_pixel),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .input_vector (iv),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_err    (frame_err),
        .frame_count  (frame_count)
    );

    typedef struct {
        int         idx;
        logic [7:0] pix;
        int         exp;
    } vec_t;

    vec_t       tbl [7];
    int         nchk = 0;
    int         nfail = 0;
    int         cyc = 0;
    int         m_idx = 0;
    int         exp_cnt = 0;
    int         exp_vec [COLS];
    logic [7:0] stim [COLS];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic vec_chk(input string name);
        int mism;
        int neg;
        mism = 0;
        neg  = 0;
        for (int i = 0; i < COLS; i++) begin
            if (iv[i] !== 9'(exp_vec[i])) mism++;
            if (iv[i][8] !== 1'b0) neg++;
        end
        chk({name, "_mismatches"}, mism, 0);
        chk({name, "_negatives"}, neg, 0);
    endtask

    task automatic send_beat(input logic [7:0] pix, input logic last);
        int n;
        s_pixel = pix;
        s_last  = last;
        s_valid = 1'b1;
        n = 0;
        while (s_ready !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) begin
            chk("ready_timeout", 1, 0);
        end else begin
            tick();
            exp_vec[m_idx] = int'(pix);
            if (m_idx == COLS - 1 || last) m_idx = 0;
            else m_idx++;
        end
    endtask

    task automatic send_frame(input int n, input logic last_final, input logic gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_valid     = 1'b0;
                frame_ready = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 3)) tick();
            end
            send_beat(stim[i], (i == n - 1) && last_final);
        end
    endtask

    task automatic handoff(input string name);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        s_valid     = 1'b0;
        exp_cnt++;
        chk({name, "_fv_low"}, frame_valid, 0);
        chk({name, "_ready_high"}, s_ready, 1);
        chk({name, "_count"}, frame_count, exp_cnt);
    endtask

    initial begin
        tbl[0] = '{idx: 0,   pix: 8'h00, exp: 0};
        tbl[1] = '{idx: 5,   pix: 8'hFF, exp: 255};
        tbl[2] = '{idx: 100, pix: 8'h80, exp: 128};
        tbl[3] = '{idx: 255, pix: 8'hFF, exp: 255};
        tbl[4] = '{idx: 256, pix: 8'h00, exp: 0};
        tbl[5] = '{idx: 300, pix: 8'h7F, exp: 127};
        tbl[6] = '{idx: 783, pix: 8'h0F, exp: 15};

        rst_n       = 1'b0;
        s_pixel     = '0;
        s_valid     = 1'b0;
        s_last      = 1'b0;
        frame_ready = 1'b0;
        for (int i = 0; i < COLS; i++) exp_vec[i] = 0;

        // Reset values
        #12;
        chk("rst_ready", s_ready, 0);
        chk("rst_fv", frame_valid, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_count", frame_count, 0);
        vec_chk("rst_vec");
        #11;
        rst_n = 1'b1;
        chk("rst_ready_before_edge", s_ready, 0);
        tick();
        chk("ready_after_first_edge", s_ready, 1);

        // Frame 1: i mod 256 with table overrides, frame_ready low
        for (int i = 0; i < COLS; i++) stim[i] = 8'(i);
        for (int k = 0; k < 7; k++) stim[tbl[k].idx] = tbl[k].pix;
        send_frame(COLS, 1'b1, 1'b0);
        chk("f1_fv", frame_valid, 1);
        chk("f1_ready_low", s_ready, 0);
        chk("f1_err", frame_err, 0);
        for (int k = 0; k < 7; k++) chk($sformatf("tbl_elem%0d", tbl[k].idx), iv[tbl[k].idx], tbl[k].exp);
        vec_chk("f1_vec");

        // HOLD with upstream pushing 8'hAA: nothing may be accepted
        s_valid = 1'b1;
        s_pixel = 8'hAA;
        s_last  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("hold_ready", s_ready, 0);
            chk("hold_fv", frame_valid, 1);
        end
        vec_chk("hold_vec");
        handoff("h1");
        vec_chk("h1_retained");

        // Short frame: s_last on beat 99
        for (int i = 0; i < 100; i++) stim[i] = 8'((i + 7) % 256);
        send_frame(100, 1'b1, 1'b0);
        s_valid = 1'b0;
        chk("short_err_pulse", frame_err, 1);
        chk("short_fv", frame_valid, 0);
        chk("short_ready", s_ready, 1);
        tick();
        chk("short_err_clear", frame_err, 0);
        for (int i = 0; i < COLS; i++) stim[i] = 8'((3 * i + 1) % 256);
        send_frame(COLS, 1'b1, 1'b0);
        s_valid = 1'b0;
        chk("f2_fv", frame_valid, 1);
        chk("f2_err", frame_err, 0);
        chk("f2_elem0", iv[0], 1);
        vec_chk("f2_vec");
        handoff("h2");

        // Missing last: 784 beats without s_last
        for (int i = 0; i < COLS; i++) stim[i] = 8'((5 * i + 2) % 256);
        send_frame(COLS, 1'b0, 1'b0);
        s_valid = 1'b0;
        chk("nolast_fv", frame_valid, 1);
        chk("nolast_err", frame_err, 1);
        tick();
        chk("nolast_err_clear", frame_err, 0);
        chk("nolast_fv_held", frame_valid, 1);
        vec_chk("nolast_vec");
        handoff("h3");

        // Random gaps, random frame_ready during fill (ignored outside HOLD)
        for (int i = 0; i < COLS; i++) stim[i] = 8'($urandom_range(0, 255));
        send_frame(COLS, 1'b1, 1'b1);
        frame_ready = 1'b0;
        s_valid     = 1'b0;
        chk("rnd_fv", frame_valid, 1);
        repeat ($urandom_range(0, 5)) tick();
        chk("rnd_fv_wait", frame_valid, 1);
        vec_chk("rnd_vec");
        handoff("h4");

        // Partial frame, then asynchronous reset mid-frame
        for (int i = 0; i < COLS; i++) stim[i] = 8'($urandom_range(0, 255));
        send_frame(400, 1'b0, 1'b1);
        s_valid     = 1'b0;
        frame_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", s_ready, 0);
        chk("midrst_fv", frame_valid, 0);
        chk("midrst_err", frame_err, 0);
        chk("midrst_count", frame_count, 0);
        for (int i = 0; i < COLS; i++) exp_vec[i] = 0;
        m_idx   = 0;
        exp_cnt = 0;
        vec_chk("midrst_vec");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("midrst_ready_back", s_ready, 1);

        // Back-to-back frame with frame_ready tied high: COLS+1 cycles
        begin
            int cyc0;
            frame_ready = 1'b1;
            for (int i = 0; i < COLS; i++) stim[i] = 8'($urandom_range(0, 255));
            cyc0 = cyc;
            send_frame(COLS, 1'b1, 1'b0);
            s_valid = 1'b0;
            chk("tp_fv", frame_valid, 1);
            tick();
            exp_cnt++;
            chk("tp_fv_low", frame_valid, 0);
            chk("tp_ready", s_ready, 1);
            chk("tp_count", frame_count, exp_cnt);
            chk("tp_cycles", cyc - cyc0, COLS + 1);
            frame_ready = 1'b0;
            vec_chk("tp_vec");
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/dnn_input_frame_loader.md
Name: dnn_input_frame_loader

Overview:
- Upstream feeder for the fully-connected inference stack.
- Accepts a serial stream of unsigned 8-bit pixels under a valid/ready handshake, one pixel per beat.
- Buffers one complete 784-pixel frame and zero-extends each pixel to the 9-bit signed format the first layer consumes.
- Holds the assembled vector stable, with `frame_valid` high, until the consumer accepts it; then refills.

Parameters:
- COLS, 784, pixels per frame and length of `input_vector`.
- PIXEL_W, 8, width of the unsigned input pixel.
- OUT_W, 9, width of each signed output element. Must satisfy OUT_W > PIXEL_W.
- CNT_W, 10, width of the pixel index counter. Must satisfy 2^CNT_W > COLS.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- s_pixel  input  PIXEL_W  unsigned pixel data.
- s_valid  input  1  `s_pixel` and `s_last` are valid.
- s_last  input  1  marks the final pixel of a frame.
- s_ready  output  1  loader can accept a beat this cycle.
- input_vector  output  OUT_W x [0:COLS-1]  signed frame vector; element i is pixel i.
- frame_valid  output  1  `input_vector` holds a complete frame.
- frame_ready  input  1  consumer accepts the held frame.
- frame_err  output  1  one-cycle pulse on a framing error.
- frame_count  output  16  number of frames handed off; wraps modulo 2^16.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = FILL, idx = 0.
  - s_ready = 0, frame_valid = 0, frame_err = 0, frame_count = 0.
  - Every `input_vector` element = 0.
  - s_ready rises on the first clk edge after rst_n deasserts.
- Registered outputs: s_ready, frame_valid and frame_err are registered.
  - s_ready = 1 exactly while in FILL, apart from the first cycle after reset.
  - frame_valid = 1 exactly while in HOLD.
- Beat acceptance: a beat is accepted only on a cycle with s_valid && s_ready.
  - Accepted pixel is written to element idx as {(OUT_W-PIXEL_W) zero bits, s_pixel}, so the value is always non-negative.
  - Nothing is written on any other cycle.
- FILL, accepted beat with idx < COLS-1 and s_last = 0: idx increments.
- FILL, accepted beat with idx < COLS-1 and s_last = 1 (short frame):
  - Pixel is written.
  - frame_err pulses next cycle.
  - idx returns to 0 and the loader stays in FILL.
  - Partial frame is abandoned; stale elements are not cleared.
- FILL, accepted beat with idx = COLS-1:
  - Pixel is written and the loader moves to HOLD.
  - Next cycle: s_ready = 0 and frame_valid = 1.
  - If s_last = 0 on this beat (long/missing last), frame_err pulses next cycle. The frame is still presented; there is no resync, and the following beats start a new frame.
  - Latency: frame_valid is high the cycle after the last pixel is accepted.
- HOLD:
  - s_ready = 0 and `input_vector` is frozen.
  - frame_ready high → on that edge, state = FILL, idx = 0, frame_count increments.
  - Next cycle: frame_valid = 0 and s_ready = 1.
  - `input_vector` keeps its contents until overwritten element by element.
  - frame_ready outside HOLD is ignored.
- Throughput: maximum is COLS+1 cycles per frame (COLS fill beats plus one handoff cycle) when frame_ready is tied high.
- Simultaneous s_valid in HOLD: not accepted, because s_ready = 0. The upstream must hold its data (standard handshake).
- Reset mid-frame or during HOLD: all state returns to reset values immediately; the partial or held frame is discarded.
- frame_count wraps from 65535 to 0.

Test Plan:
- Reset, then stream pixels 0..783 mod 256 with s_last on beat 783 and frame_ready held low → frame_valid = 1 on the cycle after beat 783. input_vector[0] = 0, [255] = 255, [256] = 0, [783] = 15. All elements ≥ 0. s_ready = 0.
- Hold state 20 cycles while driving s_valid = 1 with s_pixel = 8'hAA, then assert frame_ready for one cycle → vector unchanged throughout HOLD. No beat accepted. frame_count = 1. frame_valid = 0 and s_ready = 1 one cycle later.
- Pixel 8'hFF at index 5 → input_vector[5] = 9'sd255, not -1.
- Short frame: s_last on beat 99 → frame_err one-cycle pulse. idx restarts; a following full 784-beat frame presents correctly with element 0 taken from the new frame.
- Missing last: 784 beats with s_last = 0 → frame_valid = 1 and frame_err pulses on the same cycle.
- Random s_valid/frame_ready gaps over 3 frames with frame_ready tied high in the last frame → vectors match the stream exactly. Final frame completes in 785 cycles. Assert rst_n low mid-frame 2 → outputs zero, frame_count = 0.
